// File: rtl/ica_pkg.sv
// Shared definitions for the FastICA convergence monitor: element geometry,
// checker state encoding and the saturating magnitude helper.
package ica_pkg;

  localparam int unsigned DATA_W = 26;
  localparam int unsigned N_ELEM = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DECIDE = 2'd2
  } state_t;

  // The most-negative code has no positive twin; clamp it to the largest positive value.
  function automatic logic [DATA_W-1:0] abs_sat(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] most_neg;
    most_neg = '0;
    most_neg[DATA_W-1] = 1'b1;
    if (x == most_neg) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end else if (x[DATA_W-1]) begin
      return -x;
    end
    return x;
  endfunction

endpackage

// File: rtl/abs_sat26.sv
// Combinational saturating magnitude of one two's-complement error element.
module abs_sat26
  import ica_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] mag
);

  always_comb begin
    mag = abs_sat(x);
  end

endmodule

// File: rtl/conv_check.sv
// FastICA convergence monitor: scans the 16 error elements one per cycle, reports
// the max magnitude, tolerance verdict, saturating iteration count and sticky timeout.
module conv_check
  import ica_pkg::*;
#(
  parameter int unsigned DATA_W   = ica_pkg::DATA_W,
  parameter int unsigned TOL      = 64,
  parameter int unsigned MAX_ITER = 200,
  parameter int unsigned ITER_W   = 8
) (
  input  logic                     clk_conv,
  input  logic                     rst_conv,
  input  logic                     start_conv,
  input  logic                     clr_iter,
  input  logic [16*DATA_W-1:0]     e_flat,
  output logic                     busy,
  output logic                     done_conv,
  output logic                     converged,
  output logic [DATA_W-1:0]        max_err,
  output logic [ITER_W-1:0]        iter_cnt,
  output logic                     timeout
);

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   shadow [N_ELEM];
  logic [3:0]          idx;
  logic [DATA_W-1:0]   run_max;
  logic [DATA_W-1:0]   elem_abs;
  logic [ITER_W-1:0]   iter_inc;
  logic                conv_now;

  abs_sat26 u_abs (
    .x   (shadow[idx]),
    .mag (elem_abs)
  );

  assign busy     = (state != IDLE);
  assign conv_now = (run_max <= DATA_W'(TOL));
  assign iter_inc = (iter_cnt >= ITER_W'(MAX_ITER)) ? ITER_W'(MAX_ITER) : iter_cnt + ITER_W'(1);

  always_ff @(posedge clk_conv) begin
    if (rst_conv) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_conv) state_nxt = SCAN;
      SCAN:    if (idx == 4'(N_ELEM - 1)) state_nxt = DECIDE;
      DECIDE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_conv) begin
    if (rst_conv) begin
      for (int unsigned i = 0; i < N_ELEM; i++) shadow[i] <= '0;
      idx       <= '0;
      run_max   <= '0;
      done_conv <= 1'b0;
      converged <= 1'b0;
      max_err   <= '0;
      iter_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      done_conv <= 1'b0;
      case (state)
        IDLE: begin
          if (start_conv) begin
            for (int unsigned i = 0; i < N_ELEM; i++) shadow[i] <= e_flat[i*DATA_W +: DATA_W];
            idx     <= '0;
            run_max <= '0;
          end
        end
        SCAN: begin
          idx <= idx + 4'd1;
          if (elem_abs > run_max) run_max <= elem_abs;
        end
        DECIDE: begin
          done_conv <= 1'b1;
          max_err   <= run_max;
          converged <= conv_now;
          if (!clr_iter) begin
            iter_cnt <= iter_inc;
            if (!conv_now && iter_inc == ITER_W'(MAX_ITER)) timeout <= 1'b1;
          end
        end
        default: ;
      endcase
      // Clear applies in every state and overrides the DECIDE increment/timeout set.
      if (clr_iter) begin
        iter_cnt <= '0;
        timeout  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_check.sv
// Scoreboard bench for conv_check: randomized error matrices, integer reference model.
module tb_conv_check;

  localparam int DW   = 26;
  localparam int TOLV = 64;
  localparam int MAXI = 3;

  logic              clk;
  logic              rst_conv, start_conv, clr_iter;
  logic [16*DW-1:0]  e_flat;
  logic              busy, done_conv, converged, timeout;
  logic [DW-1:0]     max_err;
  logic [7:0]        iter_cnt;

  conv_check #(.DATA_W(DW), .TOL(TOLV), .MAX_ITER(MAXI), .ITER_W(8)) dut (
    .clk_conv   (clk),
    .rst_conv   (rst_conv),
    .start_conv (start_conv),
    .clr_iter   (clr_iter),
    .e_flat     (e_flat),
    .busy       (busy),
    .done_conv  (done_conv),
    .converged  (converged),
    .max_err    (max_err),
    .iter_cnt   (iter_cnt),
    .timeout    (timeout)
  );

  typedef struct {
    longint mx;
    bit     conv;
    int     iter;
    bit     to;
    longint start_cyc;
  } exp_t;

  exp_t   sbq[$];
  exp_t   cur;
  int     n_chk = 0, n_err = 0, done_cnt = 0;
  longint cyc = 0;
  int     m_iter = 0;
  bit     m_to = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint ref_mag(input logic [DW-1:0] b);
    longint v, a;
    v = longint'(b);
    if (b[DW-1]) v = v - (longint'(1) << DW);
    a = (v < 0) ? -v : v;
    if (a > (longint'(1) << (DW-1)) - 1) a = (longint'(1) << (DW-1)) - 1;
    return a;
  endfunction

  function automatic logic [16*DW-1:0] set_elem(input logic [16*DW-1:0] ef, input int r,
                                                input int c, input longint v);
    logic [63:0] vv;
    vv = v;
    ef[((r-1)*4 + (c-1))*DW +: DW] = vv[DW-1:0];
    return ef;
  endfunction

  function automatic logic [16*DW-1:0] rand_matrix(input int lim);
    logic [16*DW-1:0] ef;
    ef = '0;
    for (int i = 0; i < 16; i++) begin
      longint v;
      v = longint'($urandom_range(0, 2*lim)) - lim;
      ef = set_elem(ef, i/4 + 1, i%4 + 1, v);
    end
    return ef;
  endfunction

  // Reference: largest clamped magnitude, tolerance test, saturating counter, sticky timeout.
  task automatic push_exp(input logic [16*DW-1:0] ef, input bit clr_dec);
    exp_t   x;
    longint mx = 0;
    for (int i = 0; i < 16; i++) begin
      logic [DW-1:0] b;
      b = ef[i*DW +: DW];
      if (ref_mag(b) > mx) mx = ref_mag(b);
    end
    x.mx   = mx;
    x.conv = (mx <= TOLV);
    if (clr_dec) begin
      m_iter = 0;
      m_to   = 0;
    end else begin
      m_iter = (m_iter + 1 > MAXI) ? MAXI : m_iter + 1;
      if (!x.conv && m_iter == MAXI) m_to = 1;
    end
    x.iter      = m_iter;
    x.to        = m_to;
    x.start_cyc = cyc;
    sbq.push_back(x);
  endtask

  always @(negedge clk) begin
    if (done_conv === 1'b1) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_done: got done_conv=1 at cycle %0d expected none", cyc);
      end else begin
        cur = sbq.pop_front();
        chk("latency",   cyc - cur.start_cyc, 17);
        chk("max_err",   max_err, cur.mx);
        chk("converged", converged, cur.conv);
        chk("iter_cnt",  iter_cnt, cur.iter);
        chk("timeout",   timeout, cur.to);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) chk("idle_wait", busy, 0);
  endtask

  task automatic do_check(input logic [16*DW-1:0] ef, input bit clr_dec);
    wait_idle();
    e_flat     = ef;
    start_conv = 1'b1;
    @(posedge clk);
    #1;
    start_conv = 1'b0;
    push_exp(ef, clr_dec);
    e_flat = rand_matrix(1 << 20);
    if (clr_dec) begin
      repeat (16) @(posedge clk);
      @(negedge clk);
      clr_iter = 1'b1;
      @(posedge clk);
      #1;
      clr_iter = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},    busy, 0);
    chk({tag, "_done"},    done_conv, 0);
    chk({tag, "_conv"},    converged, 0);
    chk({tag, "_max_err"}, max_err, 0);
    chk({tag, "_iter"},    iter_cnt, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  initial begin
    logic [16*DW-1:0] ef, a, b;
    int               d0;

    #2_000_000;
    $display("FAIL watchdog: got no end of run expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16*DW-1:0] ef, a, b;
    int               d0;

    // Reset with start asserted: start must not survive reset.
    rst_conv   = 1'b1;
    start_conv = 1'b1;
    clr_iter   = 1'b0;
    e_flat     = rand_matrix(1000);
    repeat (2) @(posedge clk);
    #1;
    rst_conv   = 1'b0;
    start_conv = 1'b0;
    chk_zero("reset");

    ef = '0;
    ef = set_elem(ef, 2, 3, 100);
    do_check(ef, 0);

    ef = rand_matrix(64);
    ef = set_elem(ef, 4, 4, -64);
    ef = set_elem(ef, 1, 1, 63);
    do_check(ef, 0);

    ef = '0;
    ef = set_elem(ef, 1, 1, -(longint'(1) << 25));
    do_check(ef, 0);

    // Standalone clear while idle.
    wait_idle();
    clr_iter = 1'b1;
    @(posedge clk);
    #1;
    clr_iter = 1'b0;
    m_iter = 0;
    m_to   = 0;
    chk("clr_idle_iter", iter_cnt, 0);
    chk("clr_idle_timeout", timeout, 0);

    for (int k = 0; k < 4; k++) begin
      ef = rand_matrix(1000);
      ef = set_elem(ef, 3, 2, 500 + k);
      do_check(ef, 0);
    end
    do_check(rand_matrix(40), 0);
    do_check(set_elem(rand_matrix(50), 2, 2, -900), 1);

    // Start held high across a whole check: second check only at N+18.
    wait_idle();
    a = set_elem(rand_matrix(30), 1, 4, 777);
    b = rand_matrix(60);
    e_flat     = a;
    start_conv = 1'b1;
    @(posedge clk);
    #1;
    push_exp(a, 0);
    e_flat = b;
    repeat (18) @(posedge clk);
    #1;
    push_exp(b, 0);
    start_conv = 1'b0;
    e_flat = rand_matrix(5000);

    // Reset in the middle of a scan: no done, everything back to zero.
    wait_idle();
    e_flat     = set_elem(rand_matrix(10), 2, 1, 3000);
    start_conv = 1'b1;
    @(posedge clk);
    #1;
    start_conv = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_conv = 1'b1;
    @(posedge clk);
    #1;
    rst_conv = 1'b0;
    m_iter = 0;
    m_to   = 0;
    chk_zero("abort");
    d0 = done_cnt;
    repeat (25) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);

    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 3))
        0: ef = rand_matrix(64);
        1: ef = rand_matrix(80);
        2: begin
          ef = '0;
          for (int i = 0; i < 16; i++) ef[i*DW +: DW] = DW'($urandom);
        end
        default: ef = set_elem(rand_matrix(64), $urandom_range(1, 4), $urandom_range(1, 4),
                               -(longint'(1) << 25));
      endcase
      do_check(ef, $urandom_range(0, 7) == 0);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    chk("final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
